// File: rtl/canvas_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : canvas_writer                                                |
// | Description : Pixel-stream sink. Clips (hcount, vcount) to the canvas,     |
// |               maps them to linear framebuffer addresses, buffers them in   |
// |               a small FIFO and issues one BRAM write per cycle. Also runs  |
// |               the whole-canvas clear sweep.                                |
// | Option      : define CANVAS_WRITER_STATS_EN for written/clipped counters.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module canvas_writer #(
  parameter int                 H_RES       = 1280,
  parameter int                 V_RES       = 720,
  parameter int                 ADDR_W      = 20,
  parameter int                 COLOR_W     = 8,
  parameter int                 FIFO_DEPTH  = 16,
  parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic [COLOR_W-1:0] color_in,
  input  logic               data_valid_in,
  output logic               ready_out,
  input  logic               clear_in,
  output logic [ADDR_W-1:0]  bram_addr_out,
  output logic [COLOR_W-1:0] bram_data_out,
  output logic               bram_we_out,
  output logic               clear_done_out,
  output logic               overflow_out,
  output logic [15:0]        written_count_out,
  output logic [15:0]        clipped_count_out
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                CNT_W     = PTR_W + 1;
  localparam int                ENTRY_W   = ADDR_W + COLOR_W;
  localparam int                PIXELS    = H_RES * V_RES;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic [0:0] {RUN = 1'b0, CLEAR = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]    s1_addr_q, s1_addr_d;
  logic [COLOR_W-1:0]   s1_color_q, s1_color_d;
  logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_W-1:0]    sweep_q, sweep_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [COLOR_W-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic                 last_q, last_d;
  logic                 overflow_q, overflow_d;

  logic                 in_range;
  logic                 accept;
  logic                 start_clear;
  logic                 push;
  logic                 pop;
  logic [ADDR_W-1:0]    pixel_addr;
  logic [ENTRY_W-1:0]   head;

  // Ready depends only on registered occupancy so an accepted pixel always has a slot.
  assign ready_out   = (count_q + CNT_W'(s1_valid_q)) < CNT_W'(FIFO_DEPTH);
  assign in_range    = (32'(hcount_in) < H_RES) && (32'(vcount_in) < V_RES);
  assign accept      = data_valid_in && ready_out;
  assign start_clear = (state_q == RUN) && clear_in;
  assign pixel_addr  = ADDR_W'(vcount_in) * ADDR_W'(H_RES) + ADDR_W'(hcount_in);
  assign head        = fifo_mem_q[rd_ptr_q];

  // Next-state: stage 1 capture, FIFO bookkeeping, drain / sweep write selection.
  always_comb begin
    state_d    = state_q;
    s1_valid_d = 1'b0;
    s1_addr_d  = s1_addr_q;
    s1_color_d = s1_color_q;
    sweep_d    = sweep_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    done_d     = last_q;
    last_d     = 1'b0;
    overflow_d = overflow_q | (data_valid_in & ~ready_out);
    push       = s1_valid_q;
    pop        = 1'b0;

    if (accept && in_range) begin
      s1_valid_d = 1'b1;
      s1_addr_d  = pixel_addr;
      s1_color_d = color_in;
    end

    case (state_q)
      RUN: begin
        if (clear_in) begin
          // Everything in flight at this edge belongs to the old canvas.
          state_d    = CLEAR;
          s1_valid_d = 1'b0;
          push       = 1'b0;
          overflow_d = 1'b0;
          sweep_d    = '0;
        end else if (count_q != '0) begin
          pop    = 1'b1;
          we_d   = 1'b1;
          addr_d = head[ENTRY_W-1:COLOR_W];
          data_d = head[COLOR_W-1:0];
        end
      end
      CLEAR: begin
        we_d    = 1'b1;
        addr_d  = sweep_q;
        data_d  = CLEAR_COLOR;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == LAST_ADDR) begin
          state_d = RUN;
          last_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (start_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Control and output registers; reset aborts any write in progress.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= RUN;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_color_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      sweep_q    <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_color_q <= s1_color_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      sweep_q    <= sweep_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      done_q     <= done_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_in) begin
    if (push) fifo_mem_q[wr_ptr_q] <= {s1_addr_q, s1_color_q};
  end

  assign bram_we_out    = we_q;
  assign bram_addr_out  = addr_q;
  assign bram_data_out  = data_q;
  assign clear_done_out = done_q;
  assign overflow_out   = overflow_q;

`ifdef CANVAS_WRITER_STATS_EN
  logic [15:0] written_q, written_d;
  logic [15:0] clipped_q, clipped_d;

  // Saturating statistics: pixel writes (not sweep writes) and clipped pixels.
  always_comb begin
    written_d = written_q;
    clipped_d = clipped_q;
    if (pop && (written_q != 16'hFFFF)) written_d = written_q + 16'd1;
    if (accept && !in_range && (clipped_q != 16'hFFFF)) clipped_d = clipped_q + 16'd1;
  end

  // Statistics registers, cleared only by reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      written_q <= '0;
      clipped_q <= '0;
    end else begin
      written_q <= written_d;
      clipped_q <= clipped_d;
    end
  end

  assign written_count_out = written_q;
  assign clipped_count_out = clipped_q;
`else
  assign written_count_out = '0;
  assign clipped_count_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_canvas_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_canvas_writer                                             |
// | Description : Self-checking bench for canvas_writer. Instance A uses the   |
// |               full 1280x720 canvas, instance B a tiny 8x4 canvas so that   |
// |               complete clear sweeps stay short.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_canvas_writer;

`ifdef CANVAS_WRITER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    logic [19:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A stimulus / outputs
  logic        rst_a_n = 1'b0, va = 1'b0, cla = 1'b0;
  logic [10:0] ha = '0;
  logic [9:0]  vca = '0;
  logic [7:0]  ca = '0;
  logic        rdy_a, we_a, done_a, ovf_a;
  logic [19:0] addr_a;
  logic [7:0]  data_a;
  logic [15:0] wcnt_a, ccnt_a;

  // Instance B stimulus / outputs
  logic        rst_b_n = 1'b0, vb = 1'b0, clb = 1'b0;
  logic [10:0] hb = '0;
  logic [9:0]  vcb = '0;
  logic [7:0]  cb = '0;
  logic        rdy_b, we_b, done_b, ovf_b;
  logic [4:0]  addr_b;
  logic [7:0]  data_b;
  logic [15:0] wcnt_b, ccnt_b;

  canvas_writer dut_a (
    .clk_in(clk), .rst_in(rst_a_n), .hcount_in(ha), .vcount_in(vca), .color_in(ca),
    .data_valid_in(va), .ready_out(rdy_a), .clear_in(cla), .bram_addr_out(addr_a),
    .bram_data_out(data_a), .bram_we_out(we_a), .clear_done_out(done_a),
    .overflow_out(ovf_a), .written_count_out(wcnt_a), .clipped_count_out(ccnt_a)
  );

  canvas_writer #(.H_RES(8), .V_RES(4), .ADDR_W(5), .COLOR_W(8), .FIFO_DEPTH(16)) dut_b (
    .clk_in(clk), .rst_in(rst_b_n), .hcount_in(hb), .vcount_in(vcb), .color_in(cb),
    .data_valid_in(vb), .ready_out(rdy_b), .clear_in(clb), .bram_addr_out(addr_b),
    .bram_data_out(data_b), .bram_we_out(we_b), .clear_done_out(done_b),
    .overflow_out(ovf_b), .written_count_out(wcnt_b), .clipped_count_out(ccnt_b)
  );

  // Write / done monitors sampled on the falling edge.
  wr_t wr_a[$];
  wr_t wr_b[$];
  int  done_a_q[$];
  int  done_b_q[$];
  always @(negedge clk) begin
    if (we_a === 1'b1) wr_a.push_back('{addr_a, data_a, cyc});
    if (we_b === 1'b1) wr_b.push_back('{20'(addr_b), data_b, cyc});
    if (done_a === 1'b1) done_a_q.push_back(cyc);
    if (done_b === 1'b1) done_b_q.push_back(cyc);
  end

  int n_cmp = 0;
  int n_fail = 0;
  int exp_wr_a = 0, exp_clip_a = 0, exp_wr_b = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) tick;
    n_cmp++; if (rdy_a !== 1'b1 || rdy_b !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b/%b expected 1/1", rdy_a, rdy_b); end
    n_cmp++; if (we_a !== 1'b0 || we_b !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b/%b expected 0/0", we_a, we_b); end
    n_cmp++; if (addr_a !== 20'd0 || addr_b !== 5'd0 || data_a !== 8'd0 || data_b !== 8'd0) begin n_fail++; $display("FAIL reset_addr_data: got %0d/%0d %0d/%0d expected 0", addr_a, addr_b, data_a, data_b); end
    n_cmp++; if ({done_a, done_b, ovf_a, ovf_b} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {done_a, done_b, ovf_a, ovf_b}); end
    n_cmp++; if ({wcnt_a, ccnt_a, wcnt_b, ccnt_b} !== 64'd0) begin n_fail++; $display("FAIL reset_counts: got %0d %0d %0d %0d expected 0", wcnt_a, ccnt_a, wcnt_b, ccnt_b); end
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_single_pixel;
    int k;
    wr_a.delete();
    ha = 11'd3; vca = 10'd2; ca = 8'h5A; va = 1'b1;
    tick; k = cyc; va = 1'b0;
    repeat (8) tick;
    exp_wr_a++;
    n_cmp++; if (wr_a.size() != 1) begin n_fail++; $display("FAIL single_count: got %0d writes expected 1", wr_a.size()); end
    if (wr_a.size() >= 1) begin
      n_cmp++; if (wr_a[0].addr !== 20'd2563 || wr_a[0].data !== 8'h5A) begin n_fail++; $display("FAIL single_value: got addr %0d data %h expected 2563 5a", wr_a[0].addr, wr_a[0].data); end
      n_cmp++; if (wr_a[0].cyc != k + 2) begin n_fail++; $display("FAIL single_latency: got cycle %0d expected %0d", wr_a[0].cyc, k + 2); end
    end
  endtask

  task automatic test_clipping;
    wr_a.delete();
    va = 1'b1;
    ha = 11'd1280; vca = 10'd0;    tick;
    ha = 11'd0;    vca = 10'd720;  tick;
    ha = 11'd2047; vca = 10'd1023; tick;
    va = 1'b0;
    exp_clip_a += 3;
    repeat (6) tick;
    n_cmp++; if (wr_a.size() != 0) begin n_fail++; $display("FAIL clip_writes: got %0d writes expected 0", wr_a.size()); end
    n_cmp++; if (ccnt_a !== 16'(STATS ? exp_clip_a : 0)) begin n_fail++; $display("FAIL clip_count: got %0d expected %0d", ccnt_a, STATS ? exp_clip_a : 0); end
  endtask

  // Shared body for the back-to-back and random-stream scenarios on instance A.
  task automatic run_stream_a(input int n, input bit rnd, input string name);
    wr_t exp_q[$];
    int k, h, y;
    bit v;
    wr_a.delete();
    for (int i = 0; i < n; i++) begin
      v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (!rnd || $urandom_range(0, 3) != 0) begin
        h = $urandom_range(0, 1279); y = $urandom_range(0, 719);
      end else begin
        h = $urandom_range(0, 2047); y = $urandom_range(0, 1023);
      end
      va = v; ha = 11'(h); vca = 10'(y); ca = 8'($urandom);
      n_cmp++; if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL %s_ready: step %0d got %b expected 1", name, i, rdy_a); end
      tick; k = cyc;
      if (v) begin
        if (h < 1280 && y < 720) begin
          exp_q.push_back('{20'(y * 1280 + h), ca, k + 2});
          exp_wr_a++;
        end else begin
          exp_clip_a++;
        end
      end
    end
    va = 1'b0;
    repeat (6) tick;
    n_cmp++; if (wr_a.size() != exp_q.size()) begin n_fail++; $display("FAIL %s_count: got %0d writes expected %0d", name, wr_a.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < wr_a.size(); i++) begin
      n_cmp++;
      if (wr_a[i].addr !== exp_q[i].addr || wr_a[i].data !== exp_q[i].data || wr_a[i].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL %s_write%0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 name, i, wr_a[i].addr, wr_a[i].data, wr_a[i].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_cmp++; if (ovf_a !== 1'b0) begin n_fail++; $display("FAIL %s_overflow: got %b expected 0", name, ovf_a); end
  endtask

  task automatic test_back_to_back;
    run_stream_a(10, 1'b0, "b2b");
  endtask

  task automatic test_random_stream;
    run_stream_a(40, 1'b1, "rand");
    n_cmp++; if (wcnt_a !== 16'(STATS ? exp_wr_a : 0)) begin n_fail++; $display("FAIL written_count_a: got %0d expected %0d", wcnt_a, STATS ? exp_wr_a : 0); end
    n_cmp++; if (ccnt_a !== 16'(STATS ? exp_clip_a : 0)) begin n_fail++; $display("FAIL clipped_count_a: got %0d expected %0d", ccnt_a, STATS ? exp_clip_a : 0); end
  endtask

  task automatic test_clear;
    int c;
    wr_b.delete(); done_b_q.delete();
    vb = 1'b1;
    hb = 11'($urandom_range(0, 7)); vcb = 10'($urandom_range(0, 3)); cb = 8'hA1; tick;
    hb = 11'($urandom_range(0, 7)); vcb = 10'($urandom_range(0, 3)); cb = 8'hB2; tick;
    hb = 11'($urandom_range(0, 7)); vcb = 10'($urandom_range(0, 3)); cb = 8'hC3; clb = 1'b1; tick;
    vb = 1'b0; clb = 1'b0; c = cyc;
    repeat (45) tick;
    n_cmp++; if (wr_b.size() != 32) begin n_fail++; $display("FAIL clear_count: got %0d writes expected 32", wr_b.size()); end
    for (int i = 0; i < 32 && i < wr_b.size(); i++) begin
      n_cmp++;
      if (wr_b[i].addr !== 20'(i) || wr_b[i].data !== 8'd0 || wr_b[i].cyc != c + 1 + i) begin
        n_fail++;
        $display("FAIL clear_write%0d: got addr %0d data %h cyc %0d expected addr %0d data 00 cyc %0d", i, wr_b[i].addr, wr_b[i].data, wr_b[i].cyc, i, c + 1 + i);
      end
    end
    n_cmp++; if (done_b_q.size() != 1) begin n_fail++; $display("FAIL clear_done_count: got %0d pulses expected 1", done_b_q.size()); end
    if (done_b_q.size() >= 1) begin
      n_cmp++; if (done_b_q[0] != c + 33) begin n_fail++; $display("FAIL clear_done_time: got cycle %0d expected %0d", done_b_q[0], c + 33); end
    end
  endtask

  task automatic test_backpressure;
    wr_t exp_q[$];
    int c, h, y;
    wr_b.delete(); done_b_q.delete();
    clb = 1'b1; tick; clb = 1'b0; c = cyc;
    for (int i = 0; i < 20; i++) begin
      h = $urandom_range(0, 7); y = $urandom_range(0, 3);
      hb = 11'(h); vcb = 10'(y); cb = 8'($urandom); vb = 1'b1;
      n_cmp++; if (rdy_b !== 1'(i < 16)) begin n_fail++; $display("FAIL bp_ready%0d: got %b expected %b", i, rdy_b, i < 16); end
      if (i < 16) exp_q.push_back('{20'(y * 8 + h), cb, c + 33 + i});
      tick;
    end
    vb = 1'b0;
    n_cmp++; if (ovf_b !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b expected 1", ovf_b); end
    repeat (40) tick;
    exp_wr_b += 16;
    n_cmp++; if (wr_b.size() != 48) begin n_fail++; $display("FAIL bp_count: got %0d writes expected 48", wr_b.size()); end
    n_cmp++; if (done_b_q.size() != 1 || (done_b_q.size() == 1 && done_b_q[0] != c + 33)) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1 at cycle %0d", done_b_q.size(), c + 33); end
    for (int i = 0; i < 16 && i + 32 < wr_b.size(); i++) begin
      n_cmp++;
      if (wr_b[i + 32].addr !== exp_q[i].addr || wr_b[i + 32].data !== exp_q[i].data || wr_b[i + 32].cyc != exp_q[i].cyc) begin
        n_fail++;
        $display("FAIL bp_write%0d: got addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                 i, wr_b[i + 32].addr, wr_b[i + 32].data, wr_b[i + 32].cyc, exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
      end
    end
    n_cmp++; if (wcnt_b !== 16'(STATS ? exp_wr_b : 0) || ccnt_b !== 16'd0) begin n_fail++; $display("FAIL bp_stats: got %0d/%0d expected %0d/0", wcnt_b, ccnt_b, STATS ? exp_wr_b : 0); end
  endtask

  task automatic test_reset_mid_sweep;
    clb = 1'b1; tick; clb = 1'b0;
    n_cmp++; if (ovf_b !== 1'b0) begin n_fail++; $display("FAIL sweep_clears_overflow: got %b expected 0", ovf_b); end
    repeat (10) tick;
    n_cmp++; if (we_b !== 1'b1) begin n_fail++; $display("FAIL mid_sweep_we: got %b expected 1", we_b); end
    #2; rst_b_n = 1'b0; #1;
    n_cmp++; if (we_b !== 1'b0 || addr_b !== 5'd0 || data_b !== 8'd0) begin n_fail++; $display("FAIL async_reset_write: got we %b addr %0d data %h expected 0 0 00", we_b, addr_b, data_b); end
    n_cmp++; if (rdy_b !== 1'b1 || done_b !== 1'b0 || ovf_b !== 1'b0) begin n_fail++; $display("FAIL async_reset_flags: got ready %b done %b ovf %b expected 1 0 0", rdy_b, done_b, ovf_b); end
    n_cmp++; if (wcnt_b !== 16'd0 || ccnt_b !== 16'd0) begin n_fail++; $display("FAIL async_reset_counts: got %0d/%0d expected 0/0", wcnt_b, ccnt_b); end
    wr_b.delete(); done_b_q.delete();
    repeat (3) tick;
    rst_b_n = 1'b1;
    repeat (40) tick;
    n_cmp++; if (wr_b.size() != 0 || done_b_q.size() != 0) begin n_fail++; $display("FAIL post_reset_activity: got %0d writes %0d done pulses expected 0 0", wr_b.size(), done_b_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_clipping();
    test_back_to_back();
    test_random_stream();
    test_clear();
    test_backpressure();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/canvas_writer.md
# canvas_writer

Sink for the painter's pixel stream. Accepts `(hcount, vcount)` coordinate pulses, clips them to the visible canvas, converts them to linear framebuffer addresses, buffers them in a small FIFO, and issues one BRAM write per cycle. Also owns the whole-canvas clear sweep. Sits between the stroke painter and the framebuffer BRAM write port.

## Interface
- `H_RES`, 1280, canvas width in pixels
- `V_RES`, 720, canvas height in pixels
- `ADDR_W`, 20, framebuffer address width (must satisfy 2^ADDR_W ≥ H_RES·V_RES)
- `COLOR_W`, 8, pixel colour width
- `FIFO_DEPTH`, 16, pixel FIFO entries (power of two)
- `CLEAR_COLOR`, 0, value written during a clear sweep

Ports:
- `clk_in` in 1: single clock; everything is synchronous to its rising edge.
- `rst_in` in 1: reset, asynchronous, active-low.
- `hcount_in` in 11: pixel x.
- `vcount_in` in 10: pixel y.
- `color_in` in COLOR_W: colour, sampled with the pixel.
- `data_valid_in` in 1: pixel present this cycle.
- `ready_out` out 1: a pixel presented this cycle will be accepted.
- `clear_in` in 1: one-cycle request to clear the canvas.
- `bram_addr_out` out ADDR_W: write address.
- `bram_data_out` out COLOR_W: write data.
- `bram_we_out` out 1: write enable.
- `clear_done_out` out 1: one-cycle pulse when a sweep finishes.
- `overflow_out` out 1: sticky; a pixel was dropped because the block was not ready.
- `written_count_out` out 16: pixels written (see Configuration).
- `clipped_count_out` out 16: pixels clipped (see Configuration).

## Operation
- States are `RUN` and `CLEAR`. Reset enters `RUN`.
- **Reset values:**
  - `ready_out` = 1.
  - All other outputs = 0.
  - FIFO empty; counters = 0.
- **Acceptance.** A pixel is accepted when `data_valid_in && ready_out`.
  - It is out of range when `hcount_in ≥ H_RES` or `vcount_in ≥ V_RES`. This includes wrapped negative coordinates from strokes near the edge.
  - An out-of-range pixel is discarded and counts as clipped.
  - An in-range pixel enters stage 1. Stage 1 computes `addr = vcount·H_RES + hcount`, full ADDR_W width, no truncation. On the next edge stage 1 pushes `{addr, color}` into the FIFO.
- **Ready.** `ready_out = (fifo_count + stage1_valid) < FIFO_DEPTH`. It is combinational from registered state, so an accepted pixel is never lost.
- **Overflow.** If `data_valid_in && !ready_out`, the pixel is dropped and `overflow_out` sets. `overflow_out` clears only on reset or on the start of a clear sweep.
- **Drain in `RUN`.** While the FIFO is non-empty, pop one entry per cycle. The next cycle shows `bram_we_out = 1` with the popped address and data. Otherwise `bram_we_out = 0`.
- **Entering `CLEAR`.** `clear_in` sampled high in `RUN` does all of the following on that edge:
  - Flushes the FIFO and stage 1. Pre-clear pixels are discarded, not counted.
  - Clears `overflow_out`.
  - Zeroes the sweep address.
  - Enters `CLEAR`.
- **In `CLEAR`.**
  - Each cycle writes `CLEAR_COLOR` to the sweep address, then increments it.
  - Incoming pixels are still accepted into stage 1 and the FIFO, but are not drained.
  - After writing address `H_RES·V_RES−1`, the block returns to `RUN` and pulses `clear_done_out` in the following cycle. Queued pixels drain after that.
  - `clear_in` during `CLEAR` is ignored.
- Reset asserted mid-sweep or mid-drain aborts immediately to the reset values. No partial write completes after reset asserts.

## Timing
- Pixel accepted at edge k, FIFO and pipeline empty, state `RUN`:
  - stage 1 valid after edge k;
  - FIFO push at edge k+1;
  - pop at edge k+2;
  - `bram_we_out` high during the cycle after edge k+2.
  - Latency is 3 cycles; throughput is 1 pixel per cycle.
- Simultaneous push and pop keep `fifo_count` unchanged. A full FIFO with a pop frees a slot visible in `ready_out` the next cycle.
- A clear sweep is exactly H_RES·V_RES write cycles. `clear_done_out` rises one cycle after the last clear write.

## Configuration
- **`CANVAS_WRITER_STATS_EN` defined:**
  - `written_count_out` increments on every pixel write (not clear writes).
  - `clipped_count_out` increments on every clipped pixel.
  - Both are 16-bit, saturate at 0xFFFF, and reset to 0 only on reset.
- **`CANVAS_WRITER_STATS_EN` undefined:** both ports are tied to 0 and no counter logic is synthesised. All other behaviour is identical.

## Test plan
- **Single pixel.** Reset release, then one pixel at (3,2), colour 0x5A, H_RES=1280. Expect `bram_we_out` high exactly once, 3 cycles later, with addr 2563 and data 0x5A.
- **Clipping.** Pixels at (1280,0), (0,720) and (2047,1023). Expect no write. With stats enabled, `clipped_count_out` = 3.
- **Backpressure.** Hold BRAM drain blocked by a clear sweep. Push 20 valid pixels with FIFO_DEPTH=16. Expect `ready_out` to fall after 16 accepts and `overflow_out` = 1. After `clear_done_out`, expect exactly 16 writes in order.
- **Clear.** Use H_RES=8, V_RES=4. Queue 3 pixels, then pulse `clear_in`. Expect 32 writes of 0 at addresses 0..31, `clear_done_out` one cycle after address 31, and none of the 3 pixels written.
- **Back-to-back.** 10 consecutive cycles of in-range pixels. Expect 10 consecutive write cycles, in order, with no gaps and `ready_out` held high.
- **Reset mid-sweep.** Assert `rst_in` low mid-sweep. Expect `bram_we_out` to drop asynchronously, all outputs at reset values, and no `clear_done_out`.
